// File: rtl/fp_isa_pkg.sv
// Shared RV32F encoding constants for the FP instruction encoder and decoder.
// FALU op codes, funct5 values, command kinds and error codes live here.
package fp_isa_pkg;

    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SQRT   = 5'b00100;
    localparam logic [4:0] F5_SGNJ   = 5'b00101;
    localparam logic [4:0] F5_MINMAX = 5'b00110;
    localparam logic [4:0] F5_FEQ    = 5'b10100;
    localparam logic [4:0] F5_FLT    = 5'b10101;
    localparam logic [4:0] F5_FLE    = 5'b10110;

    localparam logic [4:0] FALU_ADD    = 5'd1;
    localparam logic [4:0] FALU_SUB    = 5'd2;
    localparam logic [4:0] FALU_MUL    = 5'd3;
    localparam logic [4:0] FALU_DIV    = 5'd4;
    localparam logic [4:0] FALU_SQRT   = 5'd5;
    localparam logic [4:0] FALU_SGNJ   = 5'd6;
    localparam logic [4:0] FALU_MINMAX = 5'd7;
    localparam logic [4:0] FALU_FEQ    = 5'd8;
    localparam logic [4:0] FALU_FLT    = 5'd9;
    localparam logic [4:0] FALU_FLE    = 5'd10;

    localparam logic [1:0] KIND_OPFP  = 2'd0;
    localparam logic [1:0] KIND_LOAD  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;
    localparam logic [1:0] KIND_ILL   = 2'd3;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_KIND = 2'd1;
    localparam logic [1:0] ERR_FALU = 2'd2;
    localparam logic [1:0] ERR_IMM  = 2'd3;

    // Returns {legal, funct5}; legal is 0 for op codes outside 1..10.
    function automatic logic [5:0] falu_funct5(input logic [4:0] op);
        case (op)
            FALU_ADD:    return {1'b1, F5_ADD};
            FALU_SUB:    return {1'b1, F5_SUB};
            FALU_MUL:    return {1'b1, F5_MUL};
            FALU_DIV:    return {1'b1, F5_DIV};
            FALU_SQRT:   return {1'b1, F5_SQRT};
            FALU_SGNJ:   return {1'b1, F5_SGNJ};
            FALU_MINMAX: return {1'b1, F5_MINMAX};
            FALU_FEQ:    return {1'b1, F5_FEQ};
            FALU_FLT:    return {1'b1, F5_FLT};
            FALU_FLE:    return {1'b1, F5_FLE};
            default:     return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/fp_enc_fifo.sv
// Small synchronous FIFO with registered occupancy for encoded instruction words.
// Read data is forced to zero while empty so the head output is clean after reset.
module fp_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end

endmodule

// File: rtl/fp_instr_encoder.sv
// Encodes FP micro-op commands into RV32F OP-FP / FLW / FSW words and buffers them.
// Illegal commands are consumed, not buffered, and reported as a one-cycle error pulse.
module fp_instr_encoder
    import fp_isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [4:0]       cmd_falu_opcode,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_rs1,
    input  logic [4:0]       cmd_rs2,
    input  logic [2:0]       cmd_rm,
    input  logic [1:0]       cmd_fmt,
    input  logic [2:0]       cmd_width,
    input  logic [31:0]      cmd_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_out,
    output logic [CNT_W-1:0] instr_count,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [7:0]       err_count
);
    logic [5:0]       w_f5;
    logic             w_imm_ok;
    logic [1:0]       w_err_code;
    logic [31:0]      w_word;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_err;
    logic             w_pop;
    logic [CNT_W-1:0] r_instr_count;
    logic             r_err_valid;
    logic [1:0]       r_err_code;
    logic [7:0]       r_err_count;

    assign w_imm_ok = (&cmd_imm[31:11]) | ~(|cmd_imm[31:11]);

    always_comb begin
        w_f5       = falu_funct5(cmd_falu_opcode);
        w_err_code = ERR_NONE;
        w_word     = '0;
        case (cmd_kind)
            KIND_OPFP: begin
                if (!w_f5[5]) w_err_code = ERR_FALU;
                else          w_word = {w_f5[4:0], cmd_fmt,
                                        (cmd_falu_opcode == FALU_SQRT) ? 5'd0 : cmd_rs2,
                                        cmd_rs1, cmd_rm, cmd_rd, OPC_OP_FP};
            end
            KIND_LOAD: begin
                if (!w_imm_ok) w_err_code = ERR_IMM;
                else           w_word = {cmd_imm[11:0], cmd_rs1, cmd_width, cmd_rd, OPC_LOAD_FP};
            end
            KIND_STORE: begin
                if (!w_imm_ok) w_err_code = ERR_IMM;
                else           w_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_width,
                                         cmd_imm[4:0], OPC_STORE_FP};
            end
            default: w_err_code = ERR_KIND;
        endcase
    end

    // A full FIFO blocks intake even when the head is popped this cycle.
    assign cmd_ready   = rst_n & ~w_full;
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_err       = (w_err_code != ERR_NONE);
    assign instr_valid = ~w_empty;
    assign w_pop       = instr_valid & instr_ready;

    fp_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept & ~w_err),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (instr_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_err_count   <= '0;
        end else begin
            if (w_pop) r_instr_count <= r_instr_count + CNT_W'(1);
            r_err_valid <= w_accept & w_err;
            r_err_code  <= (w_accept & w_err) ? w_err_code : ERR_NONE;
            if (w_accept && w_err && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign instr_count = r_instr_count;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_fp_instr_encoder.sv
// Self-checking bench for fp_instr_encoder: directed encodings, backpressure, errors,
// randomized traffic against an arithmetic reference model, saturation and mid-stream reset.
module tb_fp_instr_encoder;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_kind;
    logic [4:0]       cmd_falu_opcode;
    logic [4:0]       cmd_rd;
    logic [4:0]       cmd_rs1;
    logic [4:0]       cmd_rs2;
    logic [2:0]       cmd_rm;
    logic [1:0]       cmd_fmt;
    logic [2:0]       cmd_width;
    logic [31:0]      cmd_imm;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr_out;
    logic [CNT_W-1:0] instr_count;
    logic             err_valid;
    logic [1:0]       err_code;
    logic [7:0]       err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_instr_encoder #(.FIFO_DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_falu_opcode(cmd_falu_opcode),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_rm(cmd_rm), .cmd_fmt(cmd_fmt), .cmd_width(cmd_width), .cmd_imm(cmd_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_count(instr_count),
        .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: builds the word with plain arithmetic from the field layout.
    function automatic void model(input logic [1:0] k, input logic [4:0] op,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] rm,
                                  input logic [1:0] fmt, input logic [2:0] wd,
                                  input logic [31:0] imm,
                                  output logic [1:0] ecode, output logic [31:0] word);
        int     f5tab [0:10];
        int     si;
        longint w;
        f5tab = '{0, 0, 1, 2, 3, 4, 5, 6, 20, 21, 22};
        si    = $signed(imm);
        ecode = 2'd0;
        w     = 0;
        if (k == 2'd3) ecode = 2'd1;
        else if (k == 2'd0) begin
            if (op == 0 || op > 10) ecode = 2'd2;
            else w = longint'(f5tab[op]) * (longint'(1) << 27) + longint'(fmt) * (1 << 25)
                   + longint'((op == 5) ? 0 : int'(rs2)) * (1 << 20)
                   + longint'(rs1) * (1 << 15) + longint'(rm) * (1 << 12)
                   + longint'(rd) * (1 << 7) + 83;
        end else if (si < -2048 || si > 2047) ecode = 2'd3;
        else if (k == 2'd1)
            w = longint'(si & 4095) * (1 << 20) + longint'(rs1) * (1 << 15)
              + longint'(wd) * (1 << 12) + longint'(rd) * (1 << 7) + 7;
        else
            w = longint'((si >>> 5) & 127) * (longint'(1) << 25) + longint'(rs2) * (1 << 20)
              + longint'(rs1) * (1 << 15) + longint'(wd) * (1 << 12)
              + longint'(si & 31) * (1 << 7) + 39;
        word = 32'(w);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] k, input logic [4:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] rm,
                           input logic [1:0] fmt, input logic [2:0] wd, input logic [31:0] imm);
        cmd_kind = k; cmd_falu_opcode = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_rm = rm; cmd_fmt = fmt; cmd_width = wd; cmd_imm = imm;
    endtask

    // Presents the current command and waits (bounded) for the accepting edge.
    task automatic send();
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) step();
        chk("send_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    logic [31:0] q [$];
    logic [31:0] wexp;
    logic [31:0] wa, wb, wc;
    logic [1:0]  eexp;
    int          exp_cnt = 0;
    int          exp_err = 0;
    bit          acc, pop, ev;
    int          r;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; instr_ready = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_err_count", err_count, 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_valid", instr_valid, 0);

        // Directed encodings, consumer always ready.
        instr_ready = 1'b1;
        set_cmd(0, 1, 3, 1, 2, 0, 0, 0, 0);
        send();
        chk("fadd_valid", instr_valid, 1);
        chk("fadd_word", instr_out, 32'h002081D3);
        step(); exp_cnt++;
        chk("fadd_count", instr_count, 1);
        chk("fadd_drained", instr_valid, 0);

        set_cmd(1, 0, 5, 10, 0, 0, 0, 3'b010, -32'sd4);
        send();
        chk("flw_word", instr_out, 32'hFFC52287);
        step(); exp_cnt++;
        set_cmd(2, 0, 0, 2, 6, 0, 0, 3'b010, 32'd8);
        send();
        chk("fsw_word", instr_out, 32'h00612427);
        step(); exp_cnt++;

        set_cmd(0, 5, 4, 3, 7, 1, 0, 0, 0);
        model(cmd_kind, cmd_falu_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_rm, cmd_fmt,
              cmd_width, cmd_imm, eexp, wexp);
        send();
        chk("fsqrt_rs2", 32'(instr_out[24:20]), 0);
        chk("fsqrt_funct5", 32'(instr_out[31:27]), 32'b00100);
        chk("fsqrt_word", instr_out, wexp);
        step(); exp_cnt++;
        chk("count_after_directed", instr_count, 32'(exp_cnt % 16));

        // Backpressure: two fill the FIFO, the third waits for the first pop.
        instr_ready = 1'b0;
        set_cmd(0, 3, 8, 9, 10, 2, 1, 0, 0);
        model(cmd_kind, cmd_falu_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_rm, cmd_fmt,
              cmd_width, cmd_imm, eexp, wa);
        send();
        set_cmd(1, 0, 11, 12, 0, 0, 0, 3'b010, 32'd2047);
        model(cmd_kind, cmd_falu_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_rm, cmd_fmt,
              cmd_width, cmd_imm, eexp, wb);
        send();
        chk("bp_full_ready", cmd_ready, 0);
        chk("bp_head_a", instr_out, wa);
        set_cmd(2, 0, 0, 13, 14, 0, 0, 3'b010, -32'sd2048);
        model(cmd_kind, cmd_falu_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_rm, cmd_fmt,
              cmd_width, cmd_imm, eexp, wc);
        cmd_valid = 1'b1;
        step();
        chk("bp_still_blocked", cmd_ready, 0);
        chk("bp_head_stable", instr_out, wa);
        instr_ready = 1'b1;
        step(); exp_cnt++;
        chk("bp_head_b", instr_out, wb);
        chk("bp_ready_after_pop", cmd_ready, 1);
        step(); exp_cnt++;
        cmd_valid = 1'b0;
        chk("bp_head_c", instr_out, wc);
        chk("bp_count", instr_count, 32'(exp_cnt % 16));
        step(); exp_cnt++;
        chk("bp_empty", instr_valid, 0);

        // Error reporting and priority.
        set_cmd(0, 0, 1, 1, 1, 0, 0, 0, 0);
        send(); exp_err++;
        chk("err_falu_valid", err_valid, 1);
        chk("err_falu_code", err_code, 2);
        chk("err_falu_no_word", instr_valid, 0);
        chk("err_falu_count", err_count, 32'(exp_err));
        step();
        chk("err_pulse_end", err_valid, 0);
        set_cmd(1, 0, 1, 1, 0, 0, 0, 3'b010, 32'd2048);
        send(); exp_err++;
        chk("err_imm_code", err_code, 3);
        set_cmd(3, 0, 1, 1, 0, 0, 0, 0, 32'h0001_0000);
        send(); exp_err++;
        chk("err_kind_prio", err_code, 1);
        set_cmd(2, 0, 1, 1, 0, 0, 0, 0, -32'sd2049);
        send(); exp_err++;
        chk("err_store_imm", err_code, 3);
        chk("err_count_4", err_count, 32'(exp_err));
        step();

        // Randomized traffic against the model and a word queue.
        for (int n = 0; n < 400; n++) begin
            cmd_valid   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            cmd_kind        = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
            cmd_falu_opcode = 5'($urandom_range(0, 12));
            cmd_rd = 5'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom);
            cmd_rm = 3'($urandom); cmd_fmt = 2'($urandom); cmd_width = 3'($urandom);
            cmd_imm = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                  : 32'($urandom_range(0, 4095)) - 32'd2048;
            #1;
            chk("rnd_ready", cmd_ready, 32'(q.size() < 2));
            chk("rnd_valid", instr_valid, 32'(q.size() != 0));
            if (q.size() != 0) chk("rnd_word", instr_out, q[0]);
            acc = cmd_valid && (q.size() < 2);
            pop = (q.size() != 0) && instr_ready;
            model(cmd_kind, cmd_falu_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_rm, cmd_fmt,
                  cmd_width, cmd_imm, eexp, wexp);
            step();
            if (pop) begin void'(q.pop_front()); exp_cnt++; end
            ev = acc && (eexp != 0);
            if (acc && eexp == 0) q.push_back(wexp);
            if (ev && exp_err < 255) exp_err++;
            chk("rnd_err_valid", err_valid, 32'(ev));
            if (ev) chk("rnd_err_code", err_code, 32'(eexp));
            chk("rnd_instr_count", instr_count, 32'(exp_cnt % 16));
            chk("rnd_err_count", err_count, 32'(exp_err));
        end
        cmd_valid = 1'b0; instr_ready = 1'b1;
        step(); step(); step();
        exp_cnt += q.size();
        q.delete();
        chk("rnd_drained", instr_valid, 0);
        chk("rnd_final_count", instr_count, 32'(exp_cnt % 16));

        // Back-to-back errors up to saturation.
        set_cmd(3, 0, 0, 0, 0, 0, 0, 0, 0);
        cmd_valid = 1'b1;
        for (int n = 0; n < 260; n++) begin
            step();
            if (exp_err < 255) exp_err++;
            chk("b2b_err_valid", err_valid, 1);
            chk("b2b_err_count", err_count, 32'(exp_err));
        end
        cmd_valid = 1'b0;
        chk("sat_err_count", err_count, 255);
        step();
        chk("sat_pulse_end", err_valid, 0);

        // Asynchronous reset with two buffered words.
        instr_ready = 1'b0;
        set_cmd(0, 2, 1, 2, 3, 0, 0, 0, 0);
        send();
        send();
        chk("mid_full", cmd_ready, 0);
        chk("mid_valid", instr_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_count", instr_count, 0);
        chk("mid_rst_errcnt", err_count, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_out", instr_out, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", cmd_ready, 1);
        instr_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("mid_no_stale", instr_valid, 0);
            chk("mid_count_zero", instr_count, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_instr_encoder.md
Name: fp_instr_encoder

Overview:
- Inverse of the team's FP instruction decoder.
- Accepts decoded FP micro-op commands over a valid/ready stream and assembles 32-bit RV32F-format instruction words: OP-FP, FLW-class load, FSW-class store.
- Buffers encoded words in a small FIFO and streams them to an instruction-memory loader or the bench stimulus path.
- Illegal commands are dropped and reported.

Parameters:
- FIFO_DEPTH, 2: output FIFO entries; power of two, ≥2.
- CNT_W, 16: width of the emitted-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_kind  in  2  0=OP-FP, 1=load, 2=store, 3=illegal
- cmd_falu_opcode  in  5  FALU op code 1..10 (OP-FP only)
- cmd_rd  in  5  destination register
- cmd_rs1  in  5  source 1 / base register
- cmd_rs2  in  5  source 2 / store data register
- cmd_rm  in  3  rounding mode / funct3 (OP-FP)
- cmd_fmt  in  2  format field (OP-FP)
- cmd_width  in  3  funct3 width (load/store)
- cmd_imm  in  32  signed offset (load/store)
- instr_valid  out  1  encoded word available
- instr_ready  in  1  consumer takes word
- instr_out  out  32  encoded instruction, FIFO head
- instr_count  out  CNT_W  words delivered (instr_valid & instr_ready)
- err_valid  out  1  one-cycle pulse, command rejected
- err_code  out  2  1=bad kind, 2=bad falu_opcode, 3=imm out of range
- err_count  out  8  rejected commands, saturating

Behaviour:
- Reset:
  - All outputs 0.
  - FIFO pointers and occupancy cleared.
  - cmd_ready is 0 only while rst_n is low; after release it is 1 because the FIFO is empty.
  - A reset mid-stream discards all buffered words. Nothing partially delivered survives.
- Handshakes:
  - cmd_ready = (occupancy < FIFO_DEPTH), taken from registered state only.
  - When the FIFO is full, cmd_ready stays low even if a pop occurs in the same cycle. This is a deliberate single-cycle bubble.
  - instr_valid = occupancy ≠ 0. instr_out is stable while instr_valid & ~instr_ready.
- Latency: a command accepted at edge N appears on instr_out after edge N when the FIFO was empty (1 cycle).
- Simultaneous push and pop when not full: occupancy unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
- OP-FP encoding: {funct5, fmt, rs2, rs1, rm, rd, 7'b1010011}, with falu_opcode→funct5:
  - 1→00000, 2→00001, 3→00010, 4→00011, 5→00100
  - 6→00101, 7→00110, 8→10100, 9→10101, 10→10110
  - falu_opcode 5 (sqrt) forces the rs2 field to 0.
  - falu_opcode 0 or ≥11 → error 2.
- Load encoding: {imm[11:0], rs1, width, rd, 7'b0000111}.
- Store encoding: {imm[11:5], rs2, rs1, width, imm[4:0], 7'b0100111}.
- Immediate range: legal only if cmd_imm[31:11] are all equal (12-bit signed, −2048..2047); otherwise error 3.
- Error priority: kind > falu_opcode > imm.
- Errored commands:
  - Still complete the cmd handshake but are not pushed.
  - err_valid pulses for one cycle after the accept edge, with err_code.
  - err_count increments and saturates at 255.
- Back-to-back errors produce back-to-back pulses.
- instr_count wraps modulo 2^CNT_W.
- Unused fields for a given kind are ignored.

Decomposition:
- Shared package fp_isa_pkg holds:
  - opcode constants OPC_OP_FP, OPC_LOAD_FP, OPC_STORE_FP
  - funct5 constants
  - FALU op code constants FALU_ADD..FALU_FLE (1..10)
  - cmd_kind and err_code constants
  - The decoder also uses this package.
- One sub-module, fp_enc_fifo: a synchronous FIFO with registered occupancy, full/empty flags and the same clk/rst_n.
- The encode/check logic is combinational in the top level.

Test Plan:
- OP-FP fadd: falu_opcode=1, rd=3, rs1=1, rs2=2, rm=0, fmt=0, instr_ready=1 → instr_out=32'h002081D3 one cycle after accept; instr_count=1.
- Load: rd=5, rs1=10, width=3'b010, imm=−4 → 32'hFFC52287. Store: rs2=6, rs1=2, width=3'b010, imm=8 → 32'h00612427.
- Backpressure: instr_ready=0, issue 3 commands → cmd_ready drops after 2 accepts. Release ready → words emerge in order; the third command is accepted the cycle after the first pop.
- Errors:
  - falu_opcode=0 → err_valid pulse, err_code=2, no instr_valid.
  - imm=2048 on a load → err_code=3.
  - cmd_kind=3 with bad imm → err_code=1.
  - 260 errors → err_count=255.
- Fsqrt: falu_opcode=5 with rs2=7 → rs2 field [24:20]=0, funct5=00100.
- Reset mid-operation: 2 words buffered, assert rst_n=0 asynchronously → instr_valid=0, instr_count=0 immediately. After release, cmd_ready=1 and no stale word appears.
